// File: rtl/deck_shuffler_draw_if.sv
// Bus between the BlackJack datapath and the card store.
// The datapath sends shuffle/draw requests; the store returns the drawn card and deck status.
interface deck_shuffler_draw_if #(
    parameter int CARD_W = 4,
    parameter int ADDR_W = 6,
    parameter int LFSR_W = 16
);
    logic              i_Shuffle;
    logic [LFSR_W-1:0] i_Seed;
    logic              i_Draw;
    logic [CARD_W-1:0] o_Card;
    logic              o_CardValid;
    logic              o_DrawErr;
    logic              o_Busy;
    logic              o_Ready;
    logic              o_Empty;
    logic [ADDR_W:0]   o_Remaining;

    // Datapath side: issues requests and observes the deck
    modport master (
        output i_Shuffle, i_Seed, i_Draw,
        input  o_Card, o_CardValid, o_DrawErr, o_Busy, o_Ready, o_Empty, o_Remaining
    );

    // Card store side
    modport slave (
        input  i_Shuffle, i_Seed, i_Draw,
        output o_Card, o_CardValid, o_DrawErr, o_Busy, o_Ready, o_Empty, o_Remaining
    );
endinterface

// File: rtl/deck_shuffler_draw.sv
// Multi-deck card store: fills NUM_DECKS x 52 ranks in order, shuffles them
// in place with an LFSR-driven Fisher-Yates pass using rejection sampling for
// unbiased index selection, then hands out one card per draw request.
module deck_shuffler_draw #(
    parameter int NUM_DECKS = 1,
    parameter int ADDR_W    = 6,
    parameter int CARD_W    = 4,
    parameter int LFSR_W    = 16
) (
    input logic clk,
    input logic i_Reset,
    deck_shuffler_draw_if.slave bus
);
    localparam int DECK_SIZE = 52 * NUM_DECKS;
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = LFSR_W'(16'hB400);
    localparam logic [LFSR_W-1:0] LFSR_DEFAULT = LFSR_W'(16'hACE1);
    localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(DECK_SIZE - 1);
    localparam logic [ADDR_W-1:0] ONE_IDX      = ADDR_W'(1);
    localparam logic [ADDR_W:0]   FULL_COUNT   = (ADDR_W + 1)'(DECK_SIZE);
    localparam logic [ADDR_W:0]   ONE_COUNT    = (ADDR_W + 1)'(1);
    localparam logic [CARD_W-1:0] FIRST_RANK   = CARD_W'(1);
    localparam logic [CARD_W-1:0] TOP_RANK     = CARD_W'(13);

    // The address must reach every card of the combined decks
    generate
        if ((2 ** ADDR_W) < DECK_SIZE) begin : gAddrTooNarrow
            $error("deck_shuffler_draw: ADDR_W too small for NUM_DECKS");
        end
    endgenerate

    typedef enum logic [3:0] {
        IDLE, INIT, PICK, RD_I, RD_J, WR_I, WR_J, NEXT, READY
    } stateT;

    stateT             state;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsrNext;
    logic [LFSR_W-1:0] seedLoad;
    logic [ADDR_W-1:0] cardIdx;
    logic [ADDR_W-1:0] swapI;
    logic [ADDR_W-1:0] swapJ;
    logic [ADDR_W-1:0] candidate;
    logic [ADDR_W-1:0] drawPtr;
    logic [CARD_W-1:0] rank;
    logic [CARD_W-1:0] valI;
    logic [CARD_W-1:0] valJ;
    logic [CARD_W-1:0] card;
    logic              cardValid;
    logic              drawErr;
    logic              busy;
    logic              ready;
    logic              empty;
    logic [ADDR_W:0]   remaining;
    logic              shuffleAccept;
    logic              drawOk;

    logic [CARD_W-1:0] deckMem [DECK_SIZE];

    // Galois step; a zero seed would lock the LFSR so it is swapped for the default
    assign lfsrNext  = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
    assign seedLoad  = (bus.i_Seed == '0) ? LFSR_DEFAULT : bus.i_Seed;
    assign candidate = lfsr[ADDR_W-1:0];

    // Shuffle only starts from a settled deck; a draw needs a servable, non-empty deck
    // and loses to a simultaneous shuffle request
    assign shuffleAccept = bus.i_Shuffle && ((state == IDLE) || (state == READY));
    assign drawOk        = bus.i_Draw && (state == READY) && !bus.i_Shuffle && (remaining != '0);

    assign bus.o_Card       = card;
    assign bus.o_CardValid  = cardValid;
    assign bus.o_DrawErr    = drawErr;
    assign bus.o_Busy       = busy;
    assign bus.o_Ready      = ready;
    assign bus.o_Empty      = empty;
    assign bus.o_Remaining  = remaining;

    // Single write port into the card array: filled in INIT, swapped in WR_I/WR_J
    always_ff @(posedge clk) begin
        case (state)
            INIT:    deckMem[cardIdx] <= rank;
            WR_I:    deckMem[swapI]   <= valJ;
            WR_J:    deckMem[swapJ]   <= valI;
            default: ;
        endcase
    end

    // Control FSM covering init, the Fisher-Yates pass and draw service
    always_ff @(posedge clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state     <= IDLE;
            lfsr      <= LFSR_DEFAULT;
            cardIdx   <= '0;
            swapI     <= '0;
            swapJ     <= '0;
            drawPtr   <= '0;
            rank      <= FIRST_RANK;
            valI      <= '0;
            valJ      <= '0;
            card      <= '0;
            cardValid <= 1'b0;
            drawErr   <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b0;
            empty     <= 1'b1;
            remaining <= '0;
        end else begin
            cardValid <= drawOk;
            drawErr   <= bus.i_Draw && !drawOk;
            if (shuffleAccept) begin
                state   <= INIT;
                lfsr    <= seedLoad;
                cardIdx <= '0;
                rank    <= FIRST_RANK;
                busy    <= 1'b1;
                ready   <= 1'b0;
            end else begin
                case (state)
                    INIT: begin
                        rank <= (rank == TOP_RANK) ? FIRST_RANK : rank + FIRST_RANK;
                        if (cardIdx == LAST_IDX) begin
                            swapI <= LAST_IDX;
                            state <= PICK;
                        end else begin
                            cardIdx <= cardIdx + ONE_IDX;
                        end
                    end
                    PICK: begin
                        lfsr <= lfsrNext;
                        if (candidate <= swapI) begin
                            swapJ <= candidate;
                            state <= RD_I;
                        end
                    end
                    RD_I: begin
                        valI  <= deckMem[swapI];
                        state <= RD_J;
                    end
                    RD_J: begin
                        valJ  <= deckMem[swapJ];
                        state <= WR_I;
                    end
                    WR_I: state <= WR_J;
                    WR_J: state <= NEXT;
                    NEXT: begin
                        if (swapI == ONE_IDX) begin
                            state     <= READY;
                            busy      <= 1'b0;
                            ready     <= 1'b1;
                            drawPtr   <= '0;
                            remaining <= FULL_COUNT;
                            empty     <= 1'b0;
                        end else begin
                            swapI <= swapI - ONE_IDX;
                            state <= PICK;
                        end
                    end
                    READY: begin
                        if (drawOk) begin
                            card      <= deckMem[drawPtr];
                            drawPtr   <= drawPtr + ONE_IDX;
                            remaining <= remaining - ONE_COUNT;
                            empty     <= (remaining == ONE_COUNT);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_deck_shuffler_draw.sv
// Bench for the multi-deck card store: a one-deck and a two-deck instance are
// shuffled and drained, every card compared against a plain array-based
// Fisher-Yates model driven by the same LFSR rule.
module tb_deck_shuffler_draw;
    typedef struct {
        int          unit;
        logic [15:0] seed;
        int          draws;
        int          expRemaining;
        int          expEmpty;
    } vecT;

    logic clk = 1'b0;
    logic rstN;

    // 100 MHz clock
    always #5 clk = ~clk;

    deck_shuffler_draw_if #(.CARD_W(4), .ADDR_W(6), .LFSR_W(16)) bus1 ();
    deck_shuffler_draw_if #(.CARD_W(4), .ADDR_W(7), .LFSR_W(16)) bus2 ();

    deck_shuffler_draw #(.NUM_DECKS(1), .ADDR_W(6), .CARD_W(4), .LFSR_W(16)) dut1 (
        .clk(clk), .i_Reset(rstN), .bus(bus1));
    deck_shuffler_draw #(.NUM_DECKS(2), .ADDR_W(7), .CARD_W(4), .LFSR_W(16)) dut2 (
        .clk(clk), .i_Reset(rstN), .bus(bus2));

    int checks = 0;
    int errors = 0;
    int refDeck[104];
    int refPicks;
    int gotCards[104];
    int savedCards[104];
    logic [31:0] obsCard, obsValid, obsErr, obsBusy, obsReady, obsEmpty, obsRem;
    vecT vecs[12];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [15:0] lfsrStep(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Reference deck: ordered fill, then Fisher-Yates from the top with retry on out-of-range index
    task automatic modelShuffle(input logic [15:0] seed, input int deckSize, input int addrW);
        logic [15:0] r;
        int mask, c, t;
        r = (seed == 16'h0000) ? 16'hACE1 : seed;
        mask = (1 << addrW) - 1;
        refPicks = 0;
        for (int k = 0; k < deckSize; k++) refDeck[k] = (k % 13) + 1;
        for (int i = deckSize - 1; i >= 1; i--) begin
            do begin
                c = int'(r) & mask;
                r = lfsrStep(r);
                refPicks++;
            end while (c > i);
            t = refDeck[i];
            refDeck[i] = refDeck[c];
            refDeck[c] = t;
        end
    endtask

    task automatic sampleOut(input int unit);
        if (unit == 0) begin
            obsCard  = 32'(bus1.o_Card);
            obsValid = 32'(bus1.o_CardValid);
            obsErr   = 32'(bus1.o_DrawErr);
            obsBusy  = 32'(bus1.o_Busy);
            obsReady = 32'(bus1.o_Ready);
            obsEmpty = 32'(bus1.o_Empty);
            obsRem   = 32'(bus1.o_Remaining);
        end else begin
            obsCard  = 32'(bus2.o_Card);
            obsValid = 32'(bus2.o_CardValid);
            obsErr   = 32'(bus2.o_DrawErr);
            obsBusy  = 32'(bus2.o_Busy);
            obsReady = 32'(bus2.o_Ready);
            obsEmpty = 32'(bus2.o_Empty);
            obsRem   = 32'(bus2.o_Remaining);
        end
    endtask

    // Drive one cycle of inputs from a falling edge and sample the registered response one cycle later
    task automatic applyStimulus(input int unit, input logic shuffle, input logic [15:0] seed, input logic draw);
        if (unit == 0) begin
            bus1.i_Shuffle = shuffle;
            bus1.i_Seed    = seed;
            bus1.i_Draw    = draw;
        end else begin
            bus2.i_Shuffle = shuffle;
            bus2.i_Seed    = seed;
            bus2.i_Draw    = draw;
        end
        @(negedge clk);
        bus1.i_Shuffle = 1'b0;
        bus1.i_Draw    = 1'b0;
        bus2.i_Shuffle = 1'b0;
        bus2.i_Draw    = 1'b0;
        sampleOut(unit);
    endtask

    task automatic waitReady(input int unit, output int cycles);
        cycles = 0;
        sampleOut(unit);
        while (obsReady !== 32'd1 && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            sampleOut(unit);
        end
        checkOutput("readyReached", obsReady, 1);
    endtask

    task automatic checkResetState(input int unit, input string tag);
        sampleOut(unit);
        checkOutput({tag, " card"}, obsCard, 0);
        checkOutput({tag, " valid"}, obsValid, 0);
        checkOutput({tag, " drawErr"}, obsErr, 0);
        checkOutput({tag, " busy"}, obsBusy, 0);
        checkOutput({tag, " ready"}, obsReady, 0);
        checkOutput({tag, " empty"}, obsEmpty, 1);
        checkOutput({tag, " remaining"}, obsRem, 0);
    endtask

    // Drain a ready deck card by card against the reference, then check end-of-deck behaviour
    task automatic verifyDraws(input int unit, input int draws, input int expRem, input int expEmpty, input string tag);
        int deckSize;
        int rankCnt[14];
        deckSize = (unit == 0) ? 52 : 104;
        checkOutput({tag, " startRemaining"}, obsRem, deckSize);
        checkOutput({tag, " startEmpty"}, obsEmpty, 0);
        checkOutput({tag, " idleBusy"}, obsBusy, 0);
        for (int r = 0; r < 14; r++) rankCnt[r] = 0;
        for (int d = 0; d < draws; d++) begin
            applyStimulus(unit, 1'b0, 16'h0000, 1'b1);
            checkOutput({tag, " valid"}, obsValid, 1);
            checkOutput({tag, " drawErr"}, obsErr, 0);
            checkOutput({tag, " card"}, obsCard, refDeck[d]);
            checkOutput({tag, " remaining"}, obsRem, deckSize - d - 1);
            checkOutput({tag, " empty"}, obsEmpty, (d == deckSize - 1) ? 1 : 0);
            gotCards[d] = int'(obsCard);
            if (obsCard >= 1 && obsCard <= 13) rankCnt[int'(obsCard)]++;
        end
        checkOutput({tag, " endRemaining"}, obsRem, expRem);
        checkOutput({tag, " endEmpty"}, obsEmpty, expEmpty);
        if (draws == deckSize) begin
            for (int r = 1; r <= 13; r++) checkOutput({tag, " rankCount"}, rankCnt[r], deckSize / 13);
            applyStimulus(unit, 1'b0, 16'h0000, 1'b1);
            checkOutput({tag, " emptyDrawErr"}, obsErr, 1);
            checkOutput({tag, " emptyDrawValid"}, obsValid, 0);
            checkOutput({tag, " emptyCardHeld"}, obsCard, refDeck[deckSize - 1]);
            checkOutput({tag, " emptyRemaining"}, obsRem, 0);
        end
    endtask

    task automatic runDeck(input int unit, input logic [15:0] seed, input int draws,
                           input int expRem, input int expEmpty, input string tag);
        int deckSize, cycles;
        deckSize = (unit == 0) ? 52 : 104;
        modelShuffle(seed, deckSize, (unit == 0) ? 6 : 7);
        applyStimulus(unit, 1'b1, seed, 1'b0);
        checkOutput({tag, " busyOnAccept"}, obsBusy, 1);
        checkOutput({tag, " readyDropped"}, obsReady, 0);
        waitReady(unit, cycles);
        checkOutput({tag, " shuffleCycles"}, cycles, deckSize + refPicks + 5 * (deckSize - 1));
        verifyDraws(unit, draws, expRem, expEmpty, tag);
    endtask

    // Hard stop if something never returns control
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset behaviour, table of shuffles, then multi-cycle corner cases
    initial begin
        int cycles, diff, deckSize;

        vecs[0]  = '{0, 16'h0123, 52, 0, 1};
        vecs[1]  = '{0, 16'h0123, 52, 0, 1};
        vecs[2]  = '{0, 16'h0124, 52, 0, 1};
        vecs[3]  = '{0, 16'h0000, 52, 0, 1};
        vecs[4]  = '{0, 16'hACE1, 52, 0, 1};
        vecs[5]  = '{0, 16'h00FF, 10, 42, 0};
        vecs[6]  = '{0, 16'h00FF, 20, 32, 0};
        vecs[7]  = '{1, 16'hBEEF, 10, 94, 0};
        vecs[8]  = '{1, 16'hBEEF, 104, 0, 1};
        for (int v = 9; v < 12; v++) begin
            vecs[v].unit  = int'($urandom_range(0, 1));
            vecs[v].seed  = 16'($urandom_range(0, 65535));
            deckSize      = (vecs[v].unit == 0) ? 52 : 104;
            vecs[v].draws = int'($urandom_range(1, 2)) == 1 ? deckSize : int'($urandom_range(1, deckSize - 1));
            vecs[v].expRemaining = deckSize - vecs[v].draws;
            vecs[v].expEmpty     = (vecs[v].draws == deckSize) ? 1 : 0;
        end

        rstN = 1'b0;
        bus1.i_Shuffle = 1'b0; bus1.i_Seed = 16'h0000; bus1.i_Draw = 1'b0;
        bus2.i_Shuffle = 1'b0; bus2.i_Seed = 16'h0000; bus2.i_Draw = 1'b0;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkResetState(0, "powerOn");
        checkResetState(1, "powerOn2");
        applyStimulus(0, 1'b0, 16'h0000, 1'b1);
        checkOutput("idleDraw err", obsErr, 1);
        checkOutput("idleDraw valid", obsValid, 0);

        // Reset landing in the middle of a shuffle
        applyStimulus(0, 1'b1, 16'h0123, 1'b0);
        repeat (28) @(negedge clk);
        #2 rstN = 1'b0;
        #1 checkResetState(0, "asyncReset");
        @(negedge clk);
        rstN = 1'b1;
        checkResetState(0, "afterRelease");
        applyStimulus(0, 1'b0, 16'h0000, 1'b1);
        checkOutput("postResetDraw err", obsErr, 1);
        checkOutput("postResetDraw valid", obsValid, 0);
        runDeck(0, 16'h00FF, 52, 0, 1, "postReset");

        for (int v = 0; v < 12; v++) begin
            runDeck(vecs[v].unit, vecs[v].seed, vecs[v].draws,
                    vecs[v].expRemaining, vecs[v].expEmpty, $sformatf("vec%0d", v));
            if (v == 2) savedCards = gotCards;
        end

        // A neighbouring seed must give a different order than 0x0123
        modelShuffle(16'h0123, 52, 6);
        diff = 0;
        for (int k = 0; k < 52; k++) if (savedCards[k] != refDeck[k]) diff++;
        checkOutput("seedsDiffer", (diff > 0) ? 1 : 0, 1);

        // Draws and a second shuffle while busy are refused or ignored
        applyStimulus(0, 1'b1, 16'h0123, 1'b0);
        checkOutput("busySeq busy", obsBusy, 1);
        for (int p = 0; p < 3; p++) begin
            applyStimulus(0, 1'b0, 16'h0000, 1'b1);
            checkOutput("busyDraw err", obsErr, 1);
            checkOutput("busyDraw valid", obsValid, 0);
        end
        applyStimulus(0, 1'b1, 16'h4444, 1'b0);
        checkOutput("busyShuffle busy", obsBusy, 1);
        waitReady(0, cycles);
        checkOutput("busySeq cycles", cycles + 4, 52 + refPicks + 5 * 51);
        verifyDraws(0, 52, 0, 1, "busySeq");

        // Shuffle and draw on the same cycle in READY: shuffle wins
        modelShuffle(16'h0124, 52, 6);
        applyStimulus(0, 1'b1, 16'h0124, 1'b1);
        checkOutput("shuffleWins err", obsErr, 1);
        checkOutput("shuffleWins valid", obsValid, 0);
        checkOutput("shuffleWins busy", obsBusy, 1);
        checkOutput("shuffleWins ready", obsReady, 0);
        waitReady(0, cycles);
        checkOutput("shuffleWins cycles", cycles, 52 + refPicks + 5 * 51);
        verifyDraws(0, 5, 47, 0, "shuffleWins");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
